// File: rtl/bnn_pkg.sv
// Shared types and widths for the binary neural net layer.
// Common with mem_sys so address/bank widths stay in step.
package bnn_pkg;

  localparam int N_IN_DEF     = 8;
  localparam int N_NEURON_DEF = 4;
  localparam int THRESH_DEF   = N_IN_DEF / 2;

  localparam int W_ADDR_LEN_DEF = 20;
  localparam int W_SEL_LEN_DEF  = 2;
  localparam int X_ADDR_LEN_DEF = 10;
  localparam int X_SEL_LEN_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_THRESH,
    S_FINISH
  } state_t;

endpackage

// File: rtl/bnn_xnor_acc.sv
// Valid pipe, XNOR and popcount accumulator for one neuron.
// Read data lands one cycle after its request, so en is piped once.
module bnn_xnor_acc #(
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             w_bit,
  input  logic             x_bit,
  output logic [ACC_W-1:0] acc
);

  logic vld;

  // Track which cycles carry returned data and count matching bits
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      acc <= '0;
    end else begin
      vld <= en;
      if (clr) begin
        acc <= '0;
      end else if (vld) begin
        acc <= acc + ACC_W'(w_bit ~^ x_bit);
      end
    end
  end

endmodule

// File: rtl/bnn_layer_ctrl.sv
// Layer controller: walks every neuron's weight bank against one
// input bank, thresholds each popcount into a bit of y_out.
module bnn_layer_ctrl
  import bnn_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_NEURON   = N_NEURON_DEF,
  parameter int THRESH     = N_IN / 2,
  parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int W_SEL_LEN  = W_SEL_LEN_DEF,
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int X_SEL_LEN  = X_SEL_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_compute,
  input  logic [X_SEL_LEN-1:0]  cfg_x_sel,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic [W_SEL_LEN-1:0]  w_sel,
  output logic                  w_rd_en,
  input  logic                  w_rdata,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [X_SEL_LEN-1:0]  x_sel,
  output logic                  x_rd_en,
  input  logic                  x_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [N_NEURON-1:0]   y_out
);

  localparam int ACC_W = $clog2(N_IN + 1);
  localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W   = W_SEL_LEN;

  state_t           state;
  logic [I_W-1:0]   i;
  logic [J_W-1:0]   j;
  logic [ACC_W-1:0] acc;
  logic             acc_clr;
  logic             fire;

  // Clear the count on a fresh start and between neurons
  always_comb begin
    acc_clr = 1'b0;
    if (state == S_IDLE && start_compute) acc_clr = 1'b1;
    if (state == S_THRESH)                acc_clr = 1'b1;
  end

  // Threshold compare; a tie fires
  always_comb begin
    fire = ({{(32-ACC_W){1'b0}}, acc} >= 32'(THRESH));
  end

  bnn_xnor_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (w_rd_en),
    .w_bit (w_rdata),
    .x_bit (x_rdata),
    .acc   (acc)
  );

  // Sequencer: issues reads, drains, thresholds, signals done
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      i       <= '0;
      j       <= '0;
      w_addr  <= '0;
      w_sel   <= '0;
      w_rd_en <= 1'b0;
      x_addr  <= '0;
      x_sel   <= '0;
      x_rd_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_out   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_compute) begin
            state   <= S_READ;
            busy    <= 1'b1;
            i       <= '0;
            j       <= '0;
            y_out   <= '0;
            w_addr  <= '0;
            x_addr  <= '0;
            w_sel   <= '0;
            x_sel   <= cfg_x_sel;
            w_rd_en <= 1'b1;
            x_rd_en <= 1'b1;
          end
        end
        S_READ: begin
          if (i == I_W'(N_IN - 1)) begin
            state   <= S_DRAIN;
            w_rd_en <= 1'b0;
            x_rd_en <= 1'b0;
          end else begin
            i      <= i + I_W'(1);
            w_addr <= W_ADDR_LEN'(i + I_W'(1));
            x_addr <= X_ADDR_LEN'(i + I_W'(1));
          end
        end
        S_DRAIN: begin
          state <= S_THRESH;
        end
        S_THRESH: begin
          y_out[j] <= fire;
          if (j == J_W'(N_NEURON - 1)) begin
            state <= S_FINISH;
          end else begin
            state   <= S_READ;
            j       <= j + J_W'(1);
            i       <= '0;
            w_addr  <= '0;
            x_addr  <= '0;
            w_sel   <= j + J_W'(1);
            w_rd_en <= 1'b1;
            x_rd_en <= 1'b1;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_ctrl.sv
// Directed bench for bnn_layer_ctrl with a 1-cycle memory model.
// A second instance runs with THRESH=5 on the same memories.
module tb_bnn_layer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_compute;
  logic [1:0]  cfg_x_sel;

  logic [19:0] w_addr, w_addr_b;
  logic [1:0]  w_sel, w_sel_b;
  logic        w_rd_en, w_rd_en_b;
  logic        w_rdata, w_rdata_b;
  logic [9:0]  x_addr, x_addr_b;
  logic [1:0]  x_sel, x_sel_b;
  logic        x_rd_en, x_rd_en_b;
  logic        x_rdata, x_rdata_b;
  logic        busy, busy_b;
  logic        done, done_b;
  logic [3:0]  y_out, y_out_b;

  logic [7:0] w_mem [4];
  logic [7:0] x_mem [4];

  bnn_layer_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_compute (start_compute),
    .cfg_x_sel     (cfg_x_sel),
    .w_addr        (w_addr),
    .w_sel         (w_sel),
    .w_rd_en       (w_rd_en),
    .w_rdata       (w_rdata),
    .x_addr        (x_addr),
    .x_sel         (x_sel),
    .x_rd_en       (x_rd_en),
    .x_rdata       (x_rdata),
    .busy          (busy),
    .done          (done),
    .y_out         (y_out)
  );

  bnn_layer_ctrl #(.THRESH(5)) dut_t5 (
    .clk           (clk),
    .rst           (rst),
    .start_compute (start_compute),
    .cfg_x_sel     (cfg_x_sel),
    .w_addr        (w_addr_b),
    .w_sel         (w_sel_b),
    .w_rd_en       (w_rd_en_b),
    .w_rdata       (w_rdata_b),
    .x_addr        (x_addr_b),
    .x_sel         (x_sel_b),
    .x_rd_en       (x_rd_en_b),
    .x_rdata       (x_rdata_b),
    .busy          (busy_b),
    .done          (done_b),
    .y_out         (y_out_b)
  );

  // Memory model: data valid one cycle after the request
  always @(posedge clk) begin
    if (w_rd_en)   w_rdata   <= w_mem[w_sel][w_addr[2:0]];
    if (x_rd_en)   x_rdata   <= x_mem[x_sel][x_addr[2:0]];
    if (w_rd_en_b) w_rdata_b <= w_mem[w_sel_b][w_addr_b[2:0]];
    if (x_rd_en_b) x_rdata_b <= x_mem[x_sel_b][x_addr_b[2:0]];
  end

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [7:0]      xb;
    logic [1:0]      xs;
    logic [3:0]      y4;
    logic [3:0]      y5;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] w0, w1, w2, w3,
                              input logic [7:0] xb,
                              input logic [1:0] xs,
                              input logic [3:0] y4, y5);
    vec_t v;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    v.xb = xb;
    v.xs = xs;
    v.y4 = y4;
    v.y5 = y5;
    return v;
  endfunction

  // Selected input bank gets xb, every other bank its complement
  task automatic load(input vec_t v);
    for (int b = 0; b < 4; b++) begin
      w_mem[b] = v.w[b];
      x_mem[b] = (2'(b) == v.xs) ? v.xb : ~v.xb;
    end
  endtask

  task automatic run_layer(input vec_t v, input bit repulse,
                           input string tag);
    int k, done_k, rcnt, seqbad, busybad;
    logic db;
    load(v);
    cfg_x_sel = v.xs;
    start_compute = 1'b1;
    @(posedge clk);
    #1;
    start_compute = 1'b0;
    cfg_x_sel = v.xs ^ 2'b11;
    k = 0;
    done_k = -1;
    rcnt = 0;
    seqbad = 0;
    busybad = 0;
    db = 1'b0;
    while (done_k < 0 && k <= 60) begin
      if (w_rd_en !== x_rd_en) seqbad++;
      if (w_rd_en === 1'b1) begin
        if (w_addr !== 20'(rcnt % 8) || x_addr !== 10'(rcnt % 8) ||
            w_sel !== 2'(rcnt / 8) || x_sel !== v.xs)
          seqbad++;
        rcnt++;
      end
      if (x_sel !== v.xs) seqbad++;
      if (done === 1'b1) begin
        done_k = k;
        db = done_b;
        if (busy !== 1'b0) busybad++;
      end else if (busy !== 1'b1) begin
        busybad++;
      end
      if (done_k < 0) begin
        if (repulse && (k == 5 || k == 20)) start_compute = 1'b1;
        @(posedge clk);
        #1;
        start_compute = 1'b0;
        k++;
      end
    end
    chk({tag, "_latency"}, done_k, 41);
    chk({tag, "_rdseq"}, seqbad, 0);
    chk({tag, "_nreads"}, rcnt, 32);
    chk({tag, "_busy"}, busybad, 0);
    chk({tag, "_y"}, y_out, v.y4);
    chk({tag, "_y_t5"}, y_out_b, v.y5);
    chk({tag, "_done_t5"}, db, 1'b1);
  endtask

  vec_t vt [6];

  initial begin
    vt[0] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0, 4'b1111, 4'b1111);
    vt[1] = mk(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hFF, 2'd0, 4'b1111, 4'b0000);
    vt[2] = mk(8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 2'd0, 4'b0101, 4'b0101);
    vt[3] = mk(8'h0F, 8'h1F, 8'h07, 8'h00, 8'hFF, 2'd0, 4'b0011, 4'b0010);
    vt[4] = mk(8'h3C, 8'hC3, 8'h3D, 8'hFF, 8'h3C, 2'd1, 4'b1101, 4'b0101);
    vt[5] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd2, 4'b1111, 4'b1111);

    rst = 1'b1;
    start_compute = 1'b0;
    cfg_x_sel = 2'd0;
    repeat (3) @(posedge clk);
    start_compute = 1'b1;
    @(posedge clk);
    #1;
    start_compute = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_y", y_out, 4'b0000);
    chk("rst_rden", {w_rd_en, x_rd_en}, 2'b00);
    chk("rst_addr", {w_addr, x_addr, w_sel, x_sel}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);

    for (int n = 0; n < 6; n++)
      run_layer(vt[n], 1'b0, $sformatf("vec%0d", n));

    chk("hold_y", y_out, vt[5].y4);
    chk("hold_addr", w_addr, 20'd7);

    run_layer(vt[0], 1'b1, "repulse");
    begin
      int extra;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
      chk("repulse_quiet", extra, 0);
    end

    load(vt[0]);
    cfg_x_sel = 2'd0;
    start_compute = 1'b1;
    @(posedge clk);
    #1;
    start_compute = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_rst_y0", y_out[0], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_y", y_out, 4'b0000);
    chk("midrst_rden", {w_rd_en, x_rd_en}, 2'b00);
    chk("midrst_addr", {w_addr, w_sel}, 0);
    run_layer(vt[2], 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_layer_ctrl.md
BNN_LAYER_CTRL -- requirements
Module: bnn_layer_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning input bits per neuron (weights per w_sel bank).
REQ-002 SHALL have parameter N_NEURON, default 4, meaning neurons per layer (one w_sel bank each, max 2**W_SEL_LEN).
REQ-003 SHALL have parameter THRESH, default N_IN/2, meaning the popcount at or above which a neuron fires.
REQ-004 SHALL have parameters W_ADDR_LEN=20, W_SEL_LEN=2, X_ADDR_LEN=10, X_SEL_LEN=2, meaning the mem_sys address and bank widths.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 SHALL have port start_compute, input, 1, a one-cycle request to evaluate the layer.
REQ-008 SHALL have port cfg_x_sel, input, X_SEL_LEN, the input bank to use, sampled when start is accepted.
REQ-009 SHALL have ports w_addr (W_ADDR_LEN), w_sel (W_SEL_LEN) and w_rd_en (1), all outputs, forming the weight memory read request.
REQ-010 SHALL have port w_rdata, input, 1, the weight bit, valid one cycle after its request.
REQ-011 SHALL have ports x_addr (X_ADDR_LEN), x_sel (X_SEL_LEN) and x_rd_en (1), all outputs, forming the input memory read request.
REQ-012 SHALL have port x_rdata, input, 1, the input bit, valid one cycle after its request.
REQ-013 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when y_out is complete.
REQ-015 SHALL have port y_out, output, N_NEURON, with bit j as the binary activation of neuron j.

Function
REQ-016 SHALL use FSM states IDLE, READ, DRAIN, THRESH, FINISH.
REQ-017 IDLE SHALL accept start_compute when it is high at an edge: move to READ, set busy=1, neuron index j=0, bit index i=0, accumulator=0, latch cfg_x_sel, and clear y_out.
REQ-018 start_compute SHALL be ignored in every state other than IDLE, with no restart or side effect.
REQ-019 READ SHALL drive registered w_addr=i, x_addr=i, w_sel=j, x_sel=latched bank, and w_rd_en=x_rd_en=1, with i incrementing each cycle from 0 to N_IN-1, then moving to DRAIN.
REQ-020 Read data SHALL be accumulated on the edge after each request through a one-bit valid pipe: acc += ~(w_rdata ^ x_rdata).
REQ-021 DRAIN SHALL deassert rd_en for one cycle to absorb the last read datum, then move to THRESH.
REQ-022 THRESH SHALL set y_out[j] = (acc >= THRESH), with a tie firing 1; then, if j < N_NEURON-1, j++, i=0, acc=0 and go to READ; otherwise go to FINISH.
REQ-023 FINISH SHALL pulse done=1 for one cycle, clear busy and return to IDLE; a start in the cycle after done is accepted.
REQ-024 Per-neuron latency SHALL be N_IN+2 cycles.
REQ-025 done SHALL assert exactly N_NEURON*(N_IN+2)+1 cycles after the accepting edge; this is 41 at the defaults.
REQ-026 The accumulator SHALL be $clog2(N_IN+1) bits wide (4 at default) and SHALL never wrap, because it is bounded by N_IN.
REQ-027 rd_en SHALL be 0 outside READ.
REQ-028 Addresses SHALL hold their last value when idle.
REQ-029 y_out SHALL hold its value from done until the next accepted start.

Reset
REQ-030 On rst=1 at any edge, including mid-operation, the block SHALL enter IDLE and set busy=0, done=0, y_out=0, all addr/sel=0, rd_en=0, acc=0, i=j=0, and valid pipe=0.
REQ-031 rst SHALL take priority over start_compute on the same edge.
REQ-032 An in-flight read datum SHALL be discarded after reset.

Structure
REQ-033 Shared package bnn_pkg SHALL hold the FSM state type, the default N_IN/N_NEURON/THRESH values and the address/sel width constants, common with mem_sys.
REQ-034 A sub-module bnn_xnor_acc SHALL hold the valid pipe, the XNOR and the accumulator (clear, enable, count output).
REQ-035 The FSM and address counters SHALL remain in bnn_layer_ctrl.

Verification
REQ-036 Bench: all weights=1, inputs=1, pulse start -> acc=8 per neuron, y_out=4'b1111, done exactly 41 cycles after start, busy low after done.
REQ-037 Bench: weights 8'b10101010, inputs all 1 -> acc=4 = THRESH -> y_out=4'b1111 (tie fires); with THRESH=5 -> y_out=4'b0000.
REQ-038 Bench: bank j weights = ~input for j=1,3, equal for j=0,2 -> y_out=4'b0101; w_sel sequence 0,1,2,3, each for 8 consecutive addresses 0..7.
REQ-039 Bench: start re-pulsed at cycles 5 and 20 while busy -> ignored, done still at 41, single done pulse.
REQ-040 Bench: rst at cycle 15 -> next cycle busy=0, y_out=0, rd_en=0; fresh start -> correct result at 41 cycles.
REQ-041 Bench: cfg_x_sel=2 at start, changed to 1 during operation -> x_sel stays 2 for the entire run.
